amm_rr_arbiter: RTL and testbench
=================================

# amm_rr_arbiter

Round-robin arbiter that shares one Avalon MM (readdatavalid) master port, typically the slave side of the AMM-to-AXI4-Lite bridge, among P_N Avalon MM requesters. Grants one command at a time, forwards it downstream and holds it until waitrequest drops. A small ID FIFO tracks the source of each accepted read so returning readdatavalid beats reach the correct requester in order.

## Interface
- P_N, 4, number of requesters (2..8)
- P_ASIZE, 32, address width in bits
- P_DBYTES, 4, data width in bytes
- P_MAXPEND, 2, maximum accepted-but-unreturned reads (1..8)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_address  in  P_N*P_ASIZE  requester addresses; slice i belongs to requester i
- m_writedata  in  P_N*P_DBYTES*8  requester write data
- m_byteenable  in  P_N*P_DBYTES  requester byte enables
- m_write, m_read  in  P_N  requester commands
- m_waitrequest  out  P_N  per-requester waitrequest
- m_readdata  out  P_DBYTES*8  broadcast read data (= s_readdata)
- m_readdatavalid  out  P_N  per-requester read data valid
- s_address, s_writedata, s_byteenable  out  P_ASIZE / P_DBYTES*8 / P_DBYTES  downstream command fields, muxed from the granted requester
- s_write, s_read  out  1  downstream command strobes
- s_waitrequest  in  1  downstream waitrequest
- s_readdata  in  P_DBYTES*8  downstream read data
- s_readdatavalid  in  1  downstream read data valid
- err_unexp  out  1  sticky: readdatavalid received while ID FIFO empty

## Operation
- States: s_idle, s_busy.
- s_idle: a requester is eligible if m_write[i] is set, or if m_read[i] is set and the FIFO is not full. Pick the first eligible index after last_grant, wrapping modulo P_N. Register the choice in grant and last_grant, then go to s_busy. With no eligible requester, stay in s_idle.
- s_busy: drive the s_* fields from the granted slice. s_write = m_write[grant]; s_read = m_read[grant] & ~m_write[grant], so write has priority. When s_waitrequest = 0: drive m_waitrequest[grant] = 0 for that cycle. If the command was a read, push grant into the ID FIFO. Return to s_idle.
- m_waitrequest[i] = 1 at all times except the accept cycle of the granted requester.
- Requesters must hold command fields stable while waitrequest is high. The arbiter muxes them live and does not latch them.
- Read return: when s_readdatavalid = 1 and the FIFO is not empty, set m_readdatavalid[head] = 1 in the same cycle (combinational) and pop the FIFO.
- Read return with the FIFO empty: no m_readdatavalid is asserted, and err_unexp is set. err_unexp clears only on reset.
- Push and pop in the same cycle leave the count unchanged, and the FIFO must allow this even when full.
- FIFO full (P_MAXPEND entries): reads are not eligible; writes still arbitrate.

## Timing
- Reset values: state s_idle; last_grant = P_N-1, so requester 0 wins first; FIFO empty; m_waitrequest all 1; m_readdatavalid 0; s_write and s_read 0; err_unexp 0.
- Request seen at cycle 0 in s_idle gives s_read/s_write at cycle 1. With s_waitrequest = 0 at cycle 1, the accept cycle is 1.
- Back-to-back commands issue at most one every 2 cycles.
- Read data path latency is 0 cycles: readdatavalid is combinational from s_readdatavalid.
- Reset mid-command: the downstream command is dropped immediately and the FIFO is flushed. Downstream must be reset in the same cycle.

## Structure
- Package amm_arb_pkg: state_t enum {s_idle, s_busy} and a clog2-based ID width helper function.
- Sub-module amm_id_fifo: synchronous FIFO of width $clog2(P_N), depth P_MAXPEND, with push, pop, head, full and empty outputs. It must support push and pop in the same cycle when full.
- Round-robin pick is a combinational function in the top-level module.

## Test plan
- Masters 0 and 2 read concurrently with s_waitrequest = 0 and readdata returned 3 cycles after each accept -> grants in order 0, 2. m_readdatavalid[0] comes with the first beat and m_readdatavalid[2] with the second. Commands issue at cycles 1 and 3.
- All 4 masters write continuously -> grant order 0,1,2,3,0. Each m_waitrequest[i] drops exactly once per round.
- P_MAXPEND = 2, three reads, no data returned -> the third read is stalled (m_waitrequest stays 1). A write from another master is still granted. After one readdatavalid, the third read issues.
- Master 1 asserts m_write and m_read together -> only s_write is issued. The read issues on its next grant.
- s_readdatavalid pulse with the FIFO empty -> no m_readdatavalid asserted, and err_unexp = 1 until reset.
- Reset asserted in s_busy while s_waitrequest = 1 -> next cycle s_read = 0, all m_waitrequest = 1, FIFO empty, and requester 0 has priority.

Source files
------------

// File: rtl/amm_arb_pkg.sv
// amm_arb_pkg: shared types and helpers for the Avalon MM round-robin arbiter
package amm_arb_pkg;

    typedef enum logic [0:0] {s_idle, s_busy} state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amm_id_fifo.sv
// amm_id_fifo: source-ID FIFO for outstanding reads; push is accepted while full
// when a pop happens in the same cycle.
module amm_id_fifo #(
    parameter int P_W     = 2,
    parameter int P_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [P_W-1:0] din,
    input  logic           pop,
    output logic [P_W-1:0] head,
    output logic           full,
    output logic           empty
);
    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CW = $clog2(P_DEPTH + 1);

    logic [P_W-1:0] mem [2**PW];
    logic [PW-1:0]  wp, rp;
    logic [CW-1:0]  cnt;
    logic           do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(P_DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= nxt(wp);
            end
            if (do_pop)
                rp <= nxt(rp);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/amm_rr_arbiter.sv
// amm_rr_arbiter: round-robin share of one Avalon MM master port among P_N requesters,
// with in-order routing of read data back to the issuing requester.
module amm_rr_arbiter
    import amm_arb_pkg::*;
#(
    parameter int P_N       = 4,
    parameter int P_ASIZE   = 32,
    parameter int P_DBYTES  = 4,
    parameter int P_MAXPEND = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [P_N*P_ASIZE-1:0]    m_address,
    input  logic [P_N*P_DBYTES*8-1:0] m_writedata,
    input  logic [P_N*P_DBYTES-1:0]   m_byteenable,
    input  logic [P_N-1:0]            m_write,
    input  logic [P_N-1:0]            m_read,
    output logic [P_N-1:0]            m_waitrequest,
    output logic [P_DBYTES*8-1:0]     m_readdata,
    output logic [P_N-1:0]            m_readdatavalid,
    output logic [P_ASIZE-1:0]        s_address,
    output logic [P_DBYTES*8-1:0]     s_writedata,
    output logic [P_DBYTES-1:0]       s_byteenable,
    output logic                      s_write,
    output logic                      s_read,
    input  logic                      s_waitrequest,
    input  logic [P_DBYTES*8-1:0]     s_readdata,
    input  logic                      s_readdatavalid,
    output logic                      err_unexp
);
    localparam int IW = id_w(P_N);
    localparam int DW = P_DBYTES * 8;

    state_t          state, state_d;
    logic [IW-1:0]   grant, grant_d, head;
    logic [P_N-1:0]  elig, gsel;
    logic            busy, accept, push, pop, full, empty;

    function automatic logic [IW-1:0] rr_pick(input logic [P_N-1:0] e, input logic [IW-1:0] last);
        logic [IW-1:0] p;
        p = last;
        for (int k = P_N; k >= 1; k--)
            if (e[(int'(last) + k) % P_N])
                p = IW'((int'(last) + k) % P_N);
        return p;
    endfunction

    assign elig = m_write | (m_read & {P_N{!full}});

    // grant doubles as the round-robin pointer: it only changes when a new choice is made
    always_comb begin
        state_d = state;
        grant_d = grant;
        if (state == s_idle && |elig) begin
            state_d = s_busy;
            grant_d = rr_pick(elig, grant);
        end else if (state == s_busy && !s_waitrequest) begin
            state_d = s_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_idle;
            grant <= IW'(P_N - 1);
        end else begin
            state <= state_d;
            grant <= grant_d;
        end
    end

    // reset gates the strobes so an in-flight command disappears in the reset cycle itself
    assign busy            = state == s_busy && !reset;
    assign gsel            = P_N'(1) << grant;
    assign s_address       = m_address[int'(grant)*P_ASIZE +: P_ASIZE];
    assign s_writedata     = m_writedata[int'(grant)*DW +: DW];
    assign s_byteenable    = m_byteenable[int'(grant)*P_DBYTES +: P_DBYTES];
    assign s_write         = busy && m_write[grant];
    assign s_read          = busy && m_read[grant] && !m_write[grant];
    assign accept          = busy && !s_waitrequest;
    assign m_waitrequest   = accept ? ~gsel : '1;
    assign push            = accept && s_read;
    assign pop             = s_readdatavalid && !empty && !reset;
    assign m_readdatavalid = pop ? P_N'(1) << head : '0;
    assign m_readdata      = s_readdata;

    always_ff @(posedge clk) begin
        if (reset)
            err_unexp <= 1'b0;
        else if (s_readdatavalid && empty)
            err_unexp <= 1'b1;
    end

    amm_id_fifo #(
        .P_W     (IW),
        .P_DEPTH (P_MAXPEND)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_amm_rr_arbiter.sv
// tb_amm_rr_arbiter: directed stimulus with a command/read-return scoreboard for amm_rr_arbiter.
module tb_amm_rr_arbiter;
    localparam int N = 4;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [3:0]  wr;
        int          cyc;
    } cmd_t;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
    } rdv_t;

    logic          clk = 0, reset = 0;
    logic [127:0]  m_address, m_writedata;
    logic [15:0]   m_byteenable;
    logic [N-1:0]  m_write = '0, m_read = '0, m_waitrequest, m_readdatavalid;
    logic [31:0]   m_readdata, s_address, s_writedata, s_readdata = '0;
    logic [3:0]    s_byteenable;
    logic          s_write, s_read, s_waitrequest = 0, s_readdatavalid = 0, err_unexp;

    cmd_t cq[$];
    rdv_t rq[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n0 = 0;
    int   cnt[N];

    amm_rr_arbiter #(.P_N(N), .P_ASIZE(32), .P_DBYTES(4), .P_MAXPEND(2)) dut (
        .clk(clk), .reset(reset),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_write(m_write), .m_read(m_read), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_write(s_write), .s_read(s_read), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction
    function automatic logic [31:0] wd_of(input int i);
        return 32'hD000_0000 + 32'(i) * 32'h1111;
    endfunction
    function automatic logic [3:0] be_of(input int i);
        return 4'(i + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic exp_cmd(input int i, input logic w, input logic r, input int c);
        logic [3:0] v;
        v = 4'b1 << i;
        cq.push_back('{w, r, addr_of(i), wd_of(i), be_of(i), ~v, c});
    endtask

    task automatic rdv_pulse(input logic [3:0] v, input logic [31:0] d);
        rq.push_back('{v, d});
        s_readdatavalid = 1;
        s_readdata = d;
        tick();
        s_readdatavalid = 0;
    endtask

    // requester model: after each accept, drops the command it just had taken (write first)
    task automatic watch(input int i);
        int c;
        while (m_write[i] || m_read[i]) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (m_waitrequest[i] && c < 100);
            if (m_waitrequest[i]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL watch m%0d: waitrequest=1 after %0d cycles, required 0", i, c);
                m_write[i] = 0;
                m_read[i] = 0;
            end else begin
                tick();
                if (m_write[i]) m_write[i] = 0;
                else m_read[i] = 0;
            end
        end
    endtask

    task automatic req(input int i, input logic w, input logic r);
        m_write[i] = w;
        m_read[i] = r;
        fork
            begin
                automatic int k = i;
                watch(k);
            end
        join_none
    endtask

    task automatic do_reset();
        reset = 1;
        s_readdatavalid = 0;
        tick();
        tick();
        reset = 0;
    endtask

    always @(negedge clk) begin
        cmd_t e;
        rdv_t q;
        if ((s_write || s_read) && !s_waitrequest) begin
            n_cmp++;
            if (cq.size() == 0) begin
                n_bad++;
                $display("FAIL cmd: got unexpected w=%0b r=%0b addr=%h, required none", s_write, s_read, s_address);
            end else begin
                e = cq.pop_front();
                if ({s_write, s_read, s_address, s_writedata, s_byteenable, m_waitrequest} !==
                    {e.w, e.r, e.a, e.d, e.be, e.wr} || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL cmd: got w=%0b r=%0b a=%h d=%h be=%h wr=%b cyc=%0d, required w=%0b r=%0b a=%h d=%h be=%h wr=%b cyc=%0d",
                             s_write, s_read, s_address, s_writedata, s_byteenable, m_waitrequest, cyc,
                             e.w, e.r, e.a, e.d, e.be, e.wr, e.cyc);
                end
            end
        end
        if (s_readdatavalid || |m_readdatavalid) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL rdv: got unexpected rdv=%b, required none", m_readdatavalid);
            end else begin
                q = rq.pop_front();
                if ({m_readdatavalid, m_readdata} !== {q.v, q.d}) begin
                    n_bad++;
                    $display("FAIL rdv: got v=%b d=%h, required v=%b d=%h", m_readdatavalid, m_readdata, q.v, q.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_address[i*32 +: 32] = addr_of(i);
            m_writedata[i*32 +: 32] = wd_of(i);
            m_byteenable[i*4 +: 4] = be_of(i);
        end
        do_reset();
        @(negedge clk);
        check("rst_waitreq", 64'(m_waitrequest), 64'hF);
        check("rst_rdv", 64'(m_readdatavalid), 64'h0);
        check("rst_swrite", 64'(s_write), 64'h0);
        check("rst_sread", 64'(s_read), 64'h0);
        check("rst_err", 64'(err_unexp), 64'h0);
        tick();

        // masters 0 and 2 read, data returned 3 cycles after each accept
        n0 = cyc;
        req(0, 0, 1);
        req(2, 0, 1);
        exp_cmd(0, 0, 1, n0 + 1);
        exp_cmd(2, 0, 1, n0 + 3);
        repeat (4) tick();
        rdv_pulse(4'b0001, 32'hAAAA_0001);
        tick();
        rdv_pulse(4'b0100, 32'hBBBB_0002);

        // all masters write continuously
        do_reset();
        n0 = cyc;
        m_write = '1;
        for (int k = 0; k < 5; k++) exp_cmd(k % N, 1, 0, n0 + 1 + 2 * k);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (!m_waitrequest[i]) cnt[i]++;
            tick();
        end
        m_write = '0;
        check("wr_cnt0", 64'(cnt[0]), 64'd2);
        check("wr_cnt1", 64'(cnt[1]), 64'd1);
        check("wr_cnt2", 64'(cnt[2]), 64'd1);
        check("wr_cnt3", 64'(cnt[3]), 64'd1);

        // FIFO full: third read stalls, a write still goes through
        do_reset();
        n0 = cyc;
        req(0, 0, 1);
        req(1, 0, 1);
        req(2, 0, 1);
        exp_cmd(0, 0, 1, n0 + 1);
        exp_cmd(1, 0, 1, n0 + 3);
        repeat (6) tick();
        req(3, 1, 0);
        exp_cmd(3, 1, 0, n0 + 7);
        exp_cmd(2, 0, 1, n0 + 12);
        repeat (3) tick();
        @(negedge clk);
        check("full_stall", 64'(m_waitrequest), 64'hF);
        tick();
        rdv_pulse(4'b0001, 32'hCCCC_0003);
        repeat (3) tick();
        rdv_pulse(4'b0010, 32'hDDDD_0004);
        tick();
        rdv_pulse(4'b0100, 32'hEEEE_0005);

        // write and read together from master 1: write wins, read follows
        do_reset();
        n0 = cyc;
        req(1, 1, 1);
        exp_cmd(1, 1, 0, n0 + 1);
        exp_cmd(1, 0, 1, n0 + 3);
        repeat (5) tick();
        rdv_pulse(4'b0010, 32'hF0F0_0006);

        // read data with nothing outstanding
        repeat (2) tick();
        @(negedge clk);
        check("err_pre", 64'(err_unexp), 64'h0);
        tick();
        rdv_pulse(4'b0000, 32'h1234_5678);
        @(negedge clk);
        check("err_set", 64'(err_unexp), 64'h1);
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", 64'(err_unexp), 64'h1);
        tick();

        // reset during a stalled command flushes the FIFO and restores priority
        do_reset();
        @(negedge clk);
        check("err_clr", 64'(err_unexp), 64'h0);
        tick();
        n0 = cyc;
        req(1, 0, 1);
        exp_cmd(1, 0, 1, n0 + 1);
        repeat (2) tick();
        s_waitrequest = 1;
        req(0, 0, 1);
        tick();
        @(negedge clk);
        check("busy_read", 64'(s_read), 64'h1);
        check("busy_addr", 64'(s_address), 64'(addr_of(0)));
        tick();
        reset = 1;
        @(negedge clk);
        check("rst_drop_read", 64'(s_read), 64'h0);
        tick();
        reset = 0;
        s_waitrequest = 0;
        req(2, 0, 1);
        exp_cmd(0, 0, 1, n0 + 6);
        exp_cmd(2, 0, 1, n0 + 8);
        @(negedge clk);
        check("post_rst_waitreq", 64'(m_waitrequest), 64'hF);
        check("post_rst_read", 64'(s_read), 64'h0);
        tick();
        repeat (4) tick();
        rdv_pulse(4'b0001, 32'h0BAD_F00D);
        tick();
        rdv_pulse(4'b0100, 32'h600D_CAFE);

        repeat (3) tick();
        check("cmd_drained", 64'(cq.size()), 64'h0);
        check("rdv_drained", 64'(rq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
